// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - FIFO-buffered sample feeder for a sigma-delta DAC
// Buffers upstream samples, primes to START_LEVEL, then hands one word per DAC strobe.
module dac_sample_feeder #(
  parameter int                    DAC_BITLEN    = 16,
  parameter int                    FIFO_DEPTH    = 16,
  parameter int                    START_LEVEL   = 8,
  parameter logic [DAC_BITLEN-1:0] IDLE_VALUE    = {1'b1, {(DAC_BITLEN-1){1'b0}}},
  parameter bit                    UNDERRUN_HOLD = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DAC_BITLEN-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          dac_ready,
  output logic [DAC_BITLEN-1:0]         dac_input,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          running,
  output logic [15:0]                   underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    PRIME    = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DAC_BITLEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         fill_q;
  logic [DAC_BITLEN-1:0] dac_q, dac_d;
  logic [15:0]           ucnt_q, ucnt_d;
  logic                  running_q;
  logic                  push, pop;

  assign s_ready      = (fill_q != LW'(FIFO_DEPTH));
  assign push         = s_valid && s_ready;
  assign fill_level   = fill_q;
  assign dac_input    = dac_q;
  assign running      = running_q;
  assign underrun_cnt = ucnt_q;

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    ucnt_d  = ucnt_q;
    pop     = 1'b0;
    case (state_q)
      PRIME, UNDERRUN: begin
        if (fill_q >= LW'(START_LEVEL)) state_d = RUN;
      end
      RUN: begin
        if (dac_ready) begin
          if (fill_q != '0) begin
            pop   = 1'b1;
            dac_d = mem[rd_ptr];
          end else begin
            state_d = UNDERRUN;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
            if (!UNDERRUN_HOLD) dac_d = IDLE_VALUE;
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRIME;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill_q    <= '0;
      dac_q     <= IDLE_VALUE;
      ucnt_q    <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dac_q     <= dac_d;
      ucnt_q    <= ucnt_d;
      running_q <= (state_d == RUN);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb/tb_dac_sample_feeder.sv - directed vector bench for dac_sample_feeder
module tb_dac_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        dac_ready;
  logic [15:0] dac_input;
  logic [4:0]  fill_level;
  logic        running;
  logic [15:0] underrun_cnt;

  int n_vec = 0;
  int n_miss = 0;

  dac_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dac_ready    (dac_ready),
    .dac_input    (dac_input),
    .fill_level   (fill_level),
    .running      (running),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [15:0] data;
    logic        drdy;
    int          fill;
    logic [15:0] dac;
    logic        run;
    logic        rdy;
    logic [15:0] ucnt;
  } vec_t;

  vec_t tab[$];
  int   split;

  task automatic add(input logic r, input logic vl, input logic [15:0] d, input logic dr,
                     input int f, input logic [15:0] dc, input logic rn, input logic [15:0] u);
    vec_t e;
    e.rst = r; e.vld = vl; e.data = d; e.drdy = dr;
    e.fill = f; e.dac = dc; e.run = rn; e.rdy = (f != 16); e.ucnt = u;
    tab.push_back(e);
  endtask

  task automatic check(input string name, input int idx, input vec_t e);
    n_vec++;
    if (int'(fill_level) != e.fill) begin
      n_miss++;
      $display("FAIL %s[%0d] fill_level: got %0d want %0d", name, idx, fill_level, e.fill);
    end
    if (dac_input !== e.dac) begin
      n_miss++;
      $display("FAIL %s[%0d] dac_input: got %h want %h", name, idx, dac_input, e.dac);
    end
    if (running !== e.run) begin
      n_miss++;
      $display("FAIL %s[%0d] running: got %b want %b", name, idx, running, e.run);
    end
    if (s_ready !== e.rdy) begin
      n_miss++;
      $display("FAIL %s[%0d] s_ready: got %b want %b", name, idx, s_ready, e.rdy);
    end
    if (underrun_cnt !== e.ucnt) begin
      n_miss++;
      $display("FAIL %s[%0d] underrun_cnt: got %0d want %0d", name, idx, underrun_cnt, e.ucnt);
    end
  endtask

  task automatic apply(input string name, input int idx, input vec_t e);
    rst = e.rst; s_valid = e.vld; s_data = e.data; dac_ready = e.drdy;
    @(posedge clk);
    #1;
    check(name, idx, e);
  endtask

  task automatic idle_cycle();
    rst = 1'b0; s_valid = 1'b0; s_data = 16'h0; dac_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0; dac_ready = 1'b0;

    // reset and prime with dac_ready ignored while priming
    add(1, 0, 16'h0, 0, 0, 16'h8000, 0, 0);
    add(1, 1, 16'hDEAD, 1, 0, 16'h8000, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 16'h1000 + 16'(i), 0, i + 1, 16'h8000, 0, 0);
    add(0, 0, 16'h0, 1, 8, 16'h8000, 1, 0);
    add(0, 0, 16'h0, 0, 8, 16'h8000, 1, 0);
    split = tab.size();

    // drain to empty, then underrun
    for (int i = 0; i < 4; i++) add(0, 0, 16'h0, 1, 3 - i, 16'h1004 + 16'(i), 1, 0);
    add(0, 0, 16'h0, 0, 0, 16'h1007, 1, 0);
    add(0, 0, 16'h0, 1, 0, 16'h8000, 0, 1);
    // refill through UNDERRUN (strobe ignored) and on to full across pointer wrap
    add(0, 1, 16'h2000, 1, 1, 16'h8000, 0, 1);
    for (int i = 1; i < 8; i++) add(0, 1, 16'h2000 + 16'(i), 0, i + 1, 16'h8000, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 1, 16'h3000 + 16'(i), 0, 9 + i, 16'h8000, 1, 1);
    add(0, 1, 16'h3008, 0, 16, 16'h8000, 1, 1);
    add(0, 1, 16'h3009, 1, 15, 16'h2000, 1, 1);
    for (int i = 1; i < 8; i++) add(0, 0, 16'h0, 1, 15 - i, 16'h2000 + 16'(i), 1, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 16'h0, 1, 7 - i, 16'h3000 + 16'(i), 1, 1);
    // push+pop at level 1, then push into empty during a strobe
    add(0, 1, 16'h4000, 0, 1, 16'h3007, 1, 1);
    add(0, 1, 16'h4001, 1, 1, 16'h4000, 1, 1);
    add(0, 0, 16'h0, 1, 0, 16'h4001, 1, 1);
    add(0, 1, 16'h4002, 1, 1, 16'h8000, 0, 2);
    for (int i = 3; i < 10; i++) add(0, 1, 16'h4000 + 16'(i), 0, i - 1, 16'h8000, 0, 2);
    add(0, 0, 16'h0, 0, 8, 16'h8000, 1, 2);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h0, 1, 7 - i, 16'h4002 + 16'(i), 1, 2);
    // reset mid-stream beats a simultaneous push and pop
    add(1, 1, 16'h5000, 1, 0, 16'h8000, 0, 0);
    add(0, 0, 16'h0, 0, 0, 16'h8000, 0, 0);
    for (int i = 1; i < 9; i++) add(0, 1, 16'h5000 + 16'(i), 0, i, 16'h8000, 0, 0);
    add(0, 0, 16'h0, 0, 8, 16'h8000, 1, 0);
    add(0, 0, 16'h0, 1, 7, 16'h5001, 1, 0);

    for (int i = 0; i < tab.size(); i++) begin
      if (i == split) begin
        // streaming with one strobe per 256 cycles
        for (int k = 0; k < 4; k++) begin
          repeat (255) idle_cycle();
          e.rst = 0; e.vld = 0; e.data = 16'h0; e.drdy = 1;
          e.fill = 7 - k; e.dac = 16'h1000 + 16'(k); e.run = 1; e.rdy = 1; e.ucnt = 0;
          apply("stream", k, e);
        end
        e.drdy = 0;
        apply("stream_hold", 0, e);
      end
      apply("vec", i, tab[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
